// File: rtl/uart_baud_gen.sv
// Programmable baud / oversample tick generator for UART TX and RX.
// A fractional divisor (integer + FRAC_W-bit fraction) paces the oversample tick;
// OVERSAMPLE oversample ticks make one bit period, with a mid-bit sample tick.
// Divisor updates are staged in a shadow register and applied only at an
// interval boundary (or on clear) so no period is ever torn.
module uart_baud_gen #(
    parameter int unsigned CNT_W            = 16,
    parameter int unsigned FRAC_W           = 4,
    parameter int unsigned OVERSAMPLE       = 16,
    parameter int unsigned DEFAULT_DIV_INT  = 54,
    parameter int unsigned DEFAULT_DIV_FRAC = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          en_i,
    input  logic                          clear_i,
    input  logic [CNT_W-1:0]              div_int_i,
    input  logic [FRAC_W-1:0]             div_frac_i,
    input  logic                          div_load_i,
    output logic                          os_tick_o,
    output logic                          mid_tick_o,
    output logic                          bit_tick_o,
    output logic [$clog2(OVERSAMPLE)-1:0] os_idx_o,
    output logic                          div_err_o
);

    localparam int unsigned IDX_W = $clog2(OVERSAMPLE);

    localparam logic [CNT_W-1:0]  DefInt  = CNT_W'(DEFAULT_DIV_INT);
    localparam logic [FRAC_W-1:0] DefFrac = FRAC_W'(DEFAULT_DIV_FRAC);
    localparam logic [IDX_W-1:0]  IdxMax  = IDX_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0]  IdxMid  = IDX_W'(OVERSAMPLE / 2);
    localparam logic [CNT_W-1:0]  MinDiv  = CNT_W'(2);

    // Counting state
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    // Active and shadow divisors
    logic [CNT_W-1:0]  div_int_q, div_int_d;
    logic [FRAC_W-1:0] div_frac_q, div_frac_d;
    logic [CNT_W-1:0]  shd_int_q, shd_int_d;
    logic [FRAC_W-1:0] shd_frac_q, shd_frac_d;
    logic              pend_q, pend_d;
    logic              err_q, err_d;

    // Registered tick outputs
    logic os_tick_q, os_tick_d;
    logic mid_tick_q, mid_tick_d;
    logic bit_tick_q, bit_tick_d;

    logic [FRAC_W:0]  frac_sum;
    logic             carry;
    logic [CNT_W:0]   len_m1;
    logic             int_end;
    logic [IDX_W-1:0] idx_nxt;
    logic             load_ok;

    // Interval length L = div_int + carry; L-1 kept one bit wider so L = 2**CNT_W cannot wrap
    always_comb begin
        frac_sum = {1'b0, acc_q} + {1'b0, div_frac_q};
        carry    = frac_sum[FRAC_W];
        len_m1   = {1'b0, div_int_q} + {{CNT_W{1'b0}}, carry} - (CNT_W + 1)'(1);
        int_end  = en_i && !clear_i && ({1'b0, cnt_q} == len_m1);
        idx_nxt  = (idx_q == IdxMax) ? '0 : idx_q + IDX_W'(1);
        load_ok  = div_int_i >= MinDiv;
    end

    // Next-state: clear beats enable/interval end; loads land in the shadow afterwards
    always_comb begin
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        idx_d      = idx_q;
        div_int_d  = div_int_q;
        div_frac_d = div_frac_q;
        shd_int_d  = shd_int_q;
        shd_frac_d = shd_frac_q;
        pend_d     = pend_q;
        err_d      = err_q;
        os_tick_d  = 1'b0;
        mid_tick_d = 1'b0;
        bit_tick_d = 1'b0;

        if (clear_i) begin
            cnt_d = '0;
            acc_d = '0;
            idx_d = '0;
            if (pend_q) begin
                div_int_d  = shd_int_q;
                div_frac_d = shd_frac_q;
                pend_d     = 1'b0;
            end
        end else if (en_i) begin
            if (int_end) begin
                cnt_d      = '0;
                // acc advances with the divisor that timed this interval
                acc_d      = frac_sum[FRAC_W-1:0];
                idx_d      = idx_nxt;
                os_tick_d  = 1'b1;
                bit_tick_d = (idx_q == IdxMax);
                mid_tick_d = (idx_nxt == IdxMid);
                if (pend_q) begin
                    div_int_d  = shd_int_q;
                    div_frac_d = shd_frac_q;
                    pend_d     = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // A load coinciding with an apply re-arms pending for the next boundary
        if (div_load_i) begin
            if (load_ok) begin
                shd_int_d  = div_int_i;
                shd_frac_d = div_frac_i;
                pend_d     = 1'b1;
                err_d      = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // State registers with asynchronous active-high reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            idx_q      <= '0;
            div_int_q  <= DefInt;
            div_frac_q <= DefFrac;
            shd_int_q  <= DefInt;
            shd_frac_q <= DefFrac;
            pend_q     <= 1'b0;
            err_q      <= 1'b0;
            os_tick_q  <= 1'b0;
            mid_tick_q <= 1'b0;
            bit_tick_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            div_int_q  <= div_int_d;
            div_frac_q <= div_frac_d;
            shd_int_q  <= shd_int_d;
            shd_frac_q <= shd_frac_d;
            pend_q     <= pend_d;
            err_q      <= err_d;
            os_tick_q  <= os_tick_d;
            mid_tick_q <= mid_tick_d;
            bit_tick_q <= bit_tick_d;
        end
    end

    assign os_tick_o  = os_tick_q;
    assign mid_tick_o = mid_tick_q;
    assign bit_tick_o = bit_tick_q;
    assign os_idx_o   = idx_q;
    assign div_err_o  = err_q;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Self-checking bench for uart_baud_gen. The reference model tracks the absolute
// cycle at which each interval ends (a deadline), pushing it back for frozen
// cycles and recomputing it from the divisor rules on every boundary or clear.
module tb_uart_baud_gen;

    localparam int OS   = 4;
    localparam int FRW  = 4;
    localparam int FMOD = 16;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        en_i;
    logic        clear_i;
    logic [15:0] div_int_i;
    logic [3:0]  div_frac_i;
    logic        div_load_i;
    logic        os_tick_o;
    logic        mid_tick_o;
    logic        bit_tick_o;
    logic [1:0]  os_idx_o;
    logic        div_err_o;

    uart_baud_gen #(
        .CNT_W           (16),
        .FRAC_W          (FRW),
        .OVERSAMPLE      (OS),
        .DEFAULT_DIV_INT (54),
        .DEFAULT_DIV_FRAC(4)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .en_i      (en_i),
        .clear_i   (clear_i),
        .div_int_i (div_int_i),
        .div_frac_i(div_frac_i),
        .div_load_i(div_load_i),
        .os_tick_o (os_tick_o),
        .mid_tick_o(mid_tick_o),
        .bit_tick_o(bit_tick_o),
        .os_idx_o  (os_idx_o),
        .div_err_o (div_err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    int m_cyc, m_dl, m_aint, m_afrac, m_sint, m_sfrac, m_acc, m_idx;
    bit m_pend, m_err, e_os, e_mid, e_bit;

    wire [5:0] dut_vec = {os_tick_o, mid_tick_o, bit_tick_o, os_idx_o, div_err_o};

    function automatic int m_len(int acc, int fr, int di);
        return di + (((acc + fr) >= FMOD) ? 1 : 0);
    endfunction

    function automatic logic [5:0] exp_vec();
        return {e_os, e_mid, e_bit, 2'(m_idx), m_err};
    endfunction

    task automatic model_reset();
        m_aint = 54; m_afrac = 4; m_sint = 54; m_sfrac = 4;
        m_pend = 0; m_err = 0; m_acc = 0; m_idx = 0;
        e_os = 0; e_mid = 0; e_bit = 0;
        m_cyc = 0;
        m_dl = m_len(0, m_afrac, m_aint);
    endtask

    task automatic model_edge();
        int old_idx;
        m_cyc++;
        e_os = 0; e_mid = 0; e_bit = 0;
        if (clear_i) begin
            m_acc = 0; m_idx = 0;
            if (m_pend) begin m_aint = m_sint; m_afrac = m_sfrac; m_pend = 0; end
            m_dl = m_cyc + m_len(m_acc, m_afrac, m_aint);
        end else if (!en_i) begin
            m_dl++;
        end else if (m_cyc == m_dl) begin
            old_idx = m_idx;
            m_acc = (m_acc + m_afrac) % FMOD;
            m_idx = (m_idx + 1) % OS;
            e_os = 1;
            e_bit = (old_idx == OS - 1);
            e_mid = (m_idx == OS / 2);
            if (m_pend) begin m_aint = m_sint; m_afrac = m_sfrac; m_pend = 0; end
            m_dl = m_cyc + m_len(m_acc, m_afrac, m_aint);
        end
        if (div_load_i) begin
            if (div_int_i >= 2) begin
                m_sint = div_int_i; m_sfrac = div_frac_i; m_pend = 1; m_err = 0;
            end else begin
                m_err = 1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        model_edge();
        #1;
    endtask

    task automatic load(input int di, input int df);
        div_int_i = 16'(di); div_frac_i = 4'(df); div_load_i = 1'b1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; en_i = 1'b1; clear_i = 1'b0; div_load_i = 1'b0;
        div_int_i = '0; div_frac_i = '0;
        model_reset();
        repeat (3) begin
            @(posedge clk_i); #1;
            n_vec++;
            if (dut_vec !== 6'b0) begin
                n_bad++; $display("FAIL reset_hold got=%b exp=%b", dut_vec, 6'b0);
            end
        end
        rst_i = 1'b0;
        begin
            int first_os = -1;
            repeat (60) begin
                step(); n_vec++;
                if (dut_vec !== exp_vec()) begin
                    n_bad++;
                    $display("FAIL reset_run cyc=%0d got=%b exp=%b", m_cyc, dut_vec, exp_vec());
                end
                if (os_tick_o && first_os < 0) first_os = m_cyc;
            end
            n_vec++;
            if (first_os != 54) begin
                n_bad++; $display("FAIL reset_first_tick got=%0d exp=54", first_os);
            end
        end
    endtask

    task automatic test_basic();
        int last_bit = -1;
        int last_os = -1;
        load(5, 0); step(); div_load_i = 1'b0;
        clear_i = 1'b1; step(); clear_i = 1'b0;
        repeat (60) begin
            step(); n_vec++;
            if (dut_vec !== exp_vec()) begin
                n_bad++;
                $display("FAIL basic cyc=%0d got=%b exp=%b", m_cyc, dut_vec, exp_vec());
            end
            if (os_tick_o) begin
                if (last_os >= 0) begin
                    n_vec++;
                    if (m_cyc - last_os != 5) begin
                        n_bad++; $display("FAIL basic_os_gap got=%0d exp=5", m_cyc - last_os);
                    end
                end
                last_os = m_cyc;
            end
            if (bit_tick_o) begin
                if (last_bit >= 0) begin
                    n_vec++;
                    if (m_cyc - last_bit != 20) begin
                        n_bad++; $display("FAIL basic_bit_gap got=%0d exp=20", m_cyc - last_bit);
                    end
                end
                last_bit = m_cyc;
            end
        end
    endtask

    task automatic test_frac();
        int last_bit = -1;
        int last_os = -1;
        int k = 0;
        load(5, 8); step(); div_load_i = 1'b0;
        clear_i = 1'b1; step(); clear_i = 1'b0;
        repeat (70) begin
            step(); n_vec++;
            if (dut_vec !== exp_vec()) begin
                n_bad++;
                $display("FAIL frac cyc=%0d got=%b exp=%b", m_cyc, dut_vec, exp_vec());
            end
            if (os_tick_o) begin
                if (last_os >= 0) begin
                    // after the first 5-clk interval lengths alternate 6,5,6,...
                    n_vec++;
                    if (m_cyc - last_os != ((k % 2 == 1) ? 6 : 5)) begin
                        n_bad++; $display("FAIL frac_os_gap got=%0d k=%0d", m_cyc - last_os, k);
                    end
                end
                last_os = m_cyc;
                k++;
            end
            if (bit_tick_o) begin
                if (last_bit >= 0) begin
                    n_vec++;
                    if (m_cyc - last_bit != 22) begin
                        n_bad++; $display("FAIL frac_bit_gap got=%0d exp=22", m_cyc - last_bit);
                    end
                end
                last_bit = m_cyc;
            end
        end
    endtask

    task automatic test_midload();
        int t0 = -1;
        int tprev;
        int gaps[3] = '{5, 7, 7};
        load(5, 0); step(); div_load_i = 1'b0;
        clear_i = 1'b1; step(); clear_i = 1'b0;
        for (int i = 0; i < 20 && t0 < 0; i++) begin
            step(); n_vec++;
            if (dut_vec !== exp_vec()) begin
                n_bad++;
                $display("FAIL midload_pre cyc=%0d got=%b exp=%b", m_cyc, dut_vec, exp_vec());
            end
            if (os_tick_o) t0 = m_cyc;
        end
        n_vec++;
        if (t0 < 0) begin
            n_bad++; $display("FAIL midload_wait got=timeout exp=tick");
        end
        step();
        load(7, 0); step(); div_load_i = 1'b0;
        tprev = t0;
        for (int g = 0; g < 3; g++) begin
            int tn = -1;
            for (int i = 0; i < 20 && tn < 0; i++) begin
                if (os_tick_o && m_cyc > tprev) tn = m_cyc;
                else begin
                    step(); n_vec++;
                    if (dut_vec !== exp_vec()) begin
                        n_bad++;
                        $display("FAIL midload cyc=%0d got=%b exp=%b", m_cyc, dut_vec, exp_vec());
                    end
                end
            end
            n_vec++;
            if (tn - tprev != gaps[g]) begin
                n_bad++; $display("FAIL midload_gap%0d got=%0d exp=%0d", g, tn - tprev, gaps[g]);
            end
            tprev = tn;
        end
    endtask

    task automatic test_err();
        load(1, 3); step(); div_load_i = 1'b0;
        n_vec++;
        if (div_err_o !== 1'b1) begin
            n_bad++; $display("FAIL err_set got=%b exp=1", div_err_o);
        end
        repeat (30) begin
            step(); n_vec++;
            if (dut_vec !== exp_vec()) begin
                n_bad++;
                $display("FAIL err_hold cyc=%0d got=%b exp=%b", m_cyc, dut_vec, exp_vec());
            end
        end
        load(3, 0); step(); div_load_i = 1'b0;
        n_vec++;
        if (div_err_o !== 1'b0) begin
            n_bad++; $display("FAIL err_clear got=%b exp=0", div_err_o);
        end
        repeat (20) begin
            step(); n_vec++;
            if (dut_vec !== exp_vec()) begin
                n_bad++;
                $display("FAIL err_after cyc=%0d got=%b exp=%b", m_cyc, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_enable();
        int t0 = -1;
        int t1 = -1;
        for (int i = 0; i < 20 && t0 < 0; i++) begin
            step();
            if (os_tick_o) t0 = m_cyc;
        end
        step();
        en_i = 1'b0;
        repeat (10) begin
            step(); n_vec++;
            if (dut_vec !== exp_vec() || os_tick_o !== 1'b0) begin
                n_bad++;
                $display("FAIL enable_frozen cyc=%0d got=%b exp=%b", m_cyc, dut_vec, exp_vec());
            end
        end
        en_i = 1'b1;
        for (int i = 0; i < 20 && t1 < 0; i++) begin
            step(); n_vec++;
            if (dut_vec !== exp_vec()) begin
                n_bad++;
                $display("FAIL enable_resume cyc=%0d got=%b exp=%b", m_cyc, dut_vec, exp_vec());
            end
            if (os_tick_o) t1 = m_cyc;
        end
        n_vec++;
        if (t0 < 0 || t1 - t0 != 13) begin
            n_bad++; $display("FAIL enable_gap got=%0d exp=13", t1 - t0);
        end
    endtask

    task automatic test_clear();
        int te = -1;
        int t1 = -1;
        int tc;
        load(6, 0); step(); div_load_i = 1'b0;
        clear_i = 1'b1; step(); clear_i = 1'b0;
        for (int i = 0; i < 40 && te < 0; i++) begin
            step();
            if (os_tick_o && os_idx_o == 2'd2) te = m_cyc;
        end
        n_vec++;
        if (te < 0) begin
            n_bad++; $display("FAIL clear_wait got=timeout exp=idx2_tick");
        end
        repeat (3) step();
        clear_i = 1'b1; step(); clear_i = 1'b0;
        tc = m_cyc;
        n_vec++;
        if (dut_vec !== exp_vec() || os_idx_o !== 2'd0) begin
            n_bad++; $display("FAIL clear_idx got=%b exp=%b", dut_vec, exp_vec());
        end
        for (int i = 0; i < 20 && t1 < 0; i++) begin
            step(); n_vec++;
            if (dut_vec !== exp_vec()) begin
                n_bad++;
                $display("FAIL clear_run cyc=%0d got=%b exp=%b", m_cyc, dut_vec, exp_vec());
            end
            if (os_tick_o) t1 = m_cyc;
        end
        n_vec++;
        if (t1 - tc != 6) begin
            n_bad++; $display("FAIL clear_gap got=%0d exp=6", t1 - tc);
        end
    endtask

    task automatic test_reset_mid();
        int first_os = -1;
        repeat (3) step();
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        n_vec++;
        if (dut_vec !== 6'b0) begin
            n_bad++; $display("FAIL reset_mid got=%b exp=%b", dut_vec, 6'b0);
        end
        rst_i = 1'b0;
        model_reset();
        repeat (60) begin
            step(); n_vec++;
            if (dut_vec !== exp_vec()) begin
                n_bad++;
                $display("FAIL reset_mid_run cyc=%0d got=%b exp=%b", m_cyc, dut_vec, exp_vec());
            end
            if (os_tick_o && first_os < 0) first_os = m_cyc;
        end
        n_vec++;
        if (first_os != 54) begin
            n_bad++; $display("FAIL reset_mid_default got=%0d exp=54", first_os);
        end
    endtask

    task automatic test_random();
        load(4, 0); step(); div_load_i = 1'b0;
        clear_i = 1'b1; step(); clear_i = 1'b0;
        repeat (3000) begin
            en_i = ($urandom_range(0, 99) < 85);
            clear_i = ($urandom_range(0, 99) < 3);
            div_load_i = ($urandom_range(0, 99) < 5);
            div_int_i = 16'($urandom_range(0, 9));
            div_frac_i = 4'($urandom_range(0, 15));
            step(); n_vec++;
            if (dut_vec !== exp_vec()) begin
                n_bad++;
                $display("FAIL random cyc=%0d got=%b exp=%b", m_cyc, dut_vec, exp_vec());
            end
        end
        en_i = 1'b1; clear_i = 1'b0; div_load_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_frac();
        test_midload();
        test_err();
        test_enable();
        test_clear();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
